// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch program-counter unit.
// Purely declarative; no timing of its own.
// PC_RVC_EN selects 2-byte alignment (compressed ISA) instead of 4-byte.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } pc_state_e;

    // What the next-PC selector decided this cycle
    typedef enum logic [2:0] {
        SEL_HOLD    = 3'd0,
        SEL_TRAP    = 3'd1,
        SEL_REDIR   = 3'd2,
        SEL_STASH   = 3'd3,
        SEL_RELEASE = 3'd4,
        SEL_SEQ     = 3'd5
    } pc_sel_e;

    localparam int INC_WORD = 4;
    localparam int INC_HALF = 2;

    // Low address bits that must be zero for a legal redirect target
    function automatic logic [1:0] align_mask();
`ifdef PC_RVC_EN
        return 2'b01;
`else
        return 2'b11;
`endif
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux (trap > redirect > pending > sequential) with alignment check.
// Zero latency; purely combinational.
// No flow control of its own; stall and accept arrive as inputs. PC_RVC_EN enables 2-byte steps.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h100
) (
    input  logic            active,
    input  logic            in_pend,
    input  logic            stall,
    input  logic            accept,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic            is_compressed,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pend_pc,
    output pc_sel_e         sel,
    output logic [XLEN-1:0] target,
    output logic            misalign
);

    logic            aligned;
    logic [XLEN-1:0] inc;

`ifdef PC_RVC_EN
    assign inc = is_compressed ? XLEN'(INC_HALF) : XLEN'(INC_WORD);
`else
    logic unused_cmp;
    assign unused_cmp = is_compressed;
    assign inc        = XLEN'(INC_WORD);
`endif

    assign aligned = (redirect_pc[1:0] & align_mask()) == 2'b00;

    // Priority selection; a misaligned redirect is treated as absent apart from the error flag
    always_comb begin
        sel      = SEL_HOLD;
        target   = pc;
        misalign = 1'b0;
        if (active) begin
            if (trap_valid) begin
                sel    = SEL_TRAP;
                target = TRAP_VEC;
            end else begin
                misalign = redirect_valid & ~aligned;
                if (redirect_valid && aligned && !stall) begin
                    sel    = SEL_REDIR;
                    target = redirect_pc;
                end else if (redirect_valid && aligned) begin
                    sel = SEL_STASH;
                end else if (in_pend && !stall) begin
                    sel    = SEL_RELEASE;
                    target = pend_pc;
                end else if (accept && !stall) begin
                    sel    = SEL_SEQ;
                    target = pc + inc;
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: holds fetch address, picks next PC, parks redirects seen during stall, counts fetches.
// Redirect/trap visible on pc_out one cycle later; parked redirect one cycle after stall drops.
// pc_valid/if_ready handshake; stall freezes sequential advance. Build option PC_RVC_EN = 16-bit instructions.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             trap_valid,
    input  logic             if_ready,
    input  logic             is_compressed,
    output logic [XLEN-1:0]  pc_out,
    output logic             pc_valid,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    pc_state_e        state_q, state_d;
    logic [XLEN-1:0]  pc_q, pend_q, target;
    logic [CNT_W-1:0] cnt_q;
    logic             mis_q, mis_d, accept;
    pc_sel_e          sel;

    assign pc_valid     = (state_q == RUN);
    assign accept       = pc_valid & if_ready;
    assign pc_out       = pc_q;
    assign misalign_err = mis_q;
    assign fetch_cnt    = cnt_q;

    pc_next_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .active         (state_q != BOOT),
        .in_pend        (state_q == PEND),
        .stall          (stall),
        .accept         (accept),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .is_compressed  (is_compressed),
        .pc             (pc_q),
        .pend_pc        (pend_q),
        .sel            (sel),
        .target         (target),
        .misalign       (mis_d)
    );

    // Next-state: BOOT lasts one cycle; afterwards the selector's decision drives RUN/PEND
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else begin
            case (sel)
                SEL_TRAP, SEL_REDIR, SEL_RELEASE: state_d = RUN;
                SEL_STASH:                        state_d = PEND;
                default:                          state_d = state_q;
            endcase
        end
    end

    // State, PC, parked redirect, error pulse and fetch counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            pend_q  <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= target;
            mis_q   <= mis_d;
            if (sel == SEL_STASH) pend_q <= redirect_pc;
            if (accept)           cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then random traffic against a behavioural model.
// Inputs change on the falling edge; outputs are compared 1 time unit after each rising edge.
// Counter width is reduced so wrap-around is reached quickly.
module tb_pc_unit;

    localparam int          XLEN      = 32;
    localparam int          CNT_W     = 8;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] TRAP_VEC  = 32'h100;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             stall = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0;
    logic             if_ready = 1'b0, is_compressed = 1'b0;
    logic [XLEN-1:0]  redirect_pc = '0;
    logic [XLEN-1:0]  pc_out;
    logic             pc_valid, misalign_err;
    logic [CNT_W-1:0] fetch_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_boot, m_pend, m_mis;
    logic [31:0] m_pc, m_pend_pc;
    int unsigned m_cnt;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN      (XLEN),
        .RESET_VEC (RESET_VEC),
        .TRAP_VEC  (TRAP_VEC),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .if_ready       (if_ready),
        .is_compressed  (is_compressed),
        .pc_out         (pc_out),
        .pc_valid       (pc_valid),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_aligned(input logic [31:0] a);
`ifdef PC_RVC_EN
        return a[0] == 1'b0;
`else
        return a[1:0] == 2'b00;
`endif
    endfunction

    function automatic logic [31:0] step_size(input bit cmp);
`ifdef PC_RVC_EN
        return cmp ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_step();
        bit acc;
        bit mis;
        acc = !m_boot && !m_pend && if_ready;
        mis = 1'b0;
        if (!reset_n) begin
            m_boot = 1'b1; m_pend = 1'b0; m_pc = RESET_VEC; m_cnt = 0; m_mis = 1'b0;
            return;
        end
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (trap_valid) begin
            m_pc = TRAP_VEC; m_pend = 1'b0;
        end else if (redirect_valid && is_aligned(redirect_pc)) begin
            if (!stall) begin m_pc = redirect_pc; m_pend = 1'b0; end
            else        begin m_pend_pc = redirect_pc; m_pend = 1'b1; end
        end else begin
            mis = redirect_valid;
            if (m_pend && !stall) begin
                m_pc = m_pend_pc; m_pend = 1'b0;
            end else if (acc && !stall) begin
                m_pc = m_pc + step_size(is_compressed);
            end
        end
        if (acc) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_mis = mis;
    endtask

    task automatic compare_all();
        check("pc_out",   64'(pc_out),       64'(m_pc));
        check("pc_valid", 64'(pc_valid),     64'(!m_boot && !m_pend));
        check("misalign", 64'(misalign_err), 64'(m_mis));
        check("fetch_cnt", 64'(fetch_cnt),   64'(m_cnt));
    endtask

    // One clock: apply inputs on the falling edge, update model on the rising edge, then compare
    task automatic cyc(input bit rst_n, input bit st, input bit rv, input logic [31:0] rpc,
                       input bit tr, input bit rdy, input bit cmp);
        @(negedge clk);
        reset_n = rst_n; stall = st; redirect_valid = rv; redirect_pc = rpc;
        trap_valid = tr; if_ready = rdy; is_compressed = cmp;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        m_boot = 1'b1; m_pend = 1'b0; m_mis = 1'b0; m_pc = RESET_VEC; m_pend_pc = '0; m_cnt = 0;

        // Reset and release: one idle cycle then 0,4,8,C
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("rst_pc", 64'(pc_out), 64'(RESET_VEC));
        check("rst_valid", 64'(pc_valid), 64'd0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("boot_valid", 64'(pc_valid), 64'd1);
        repeat (3) cyc(1, 0, 0, 0, 0, 1, 0);
        check("seq_pc", 64'(pc_out), 64'hC);
        check("seq_cnt", 64'(fetch_cnt), 64'd3);

        // Aligned redirect, then misaligned one is dropped
        cyc(1, 0, 1, 32'h200, 0, 1, 0);
        check("redir_pc", 64'(pc_out), 64'h200);
        cyc(1, 0, 1, 32'h202, 0, 1, 0);
        check("misal_pulse", 64'(misalign_err), 64'd1);
        check("misal_seq", 64'(pc_out), 64'h204);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("misal_clear", 64'(misalign_err), 64'd0);

        // Stalled redirects: last one wins when stall drops
        cyc(1, 1, 1, 32'h300, 0, 1, 0);
        cyc(1, 1, 1, 32'h400, 0, 1, 0);
        check("pend_valid", 64'(pc_valid), 64'd0);
        cyc(1, 1, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("pend_release", 64'(pc_out), 64'h400);

        // Trap beats a stalled redirect and clears the parked one
        cyc(1, 1, 1, 32'h600, 0, 1, 0);
        cyc(1, 1, 1, 32'h500, 1, 1, 0);
        check("trap_pc", 64'(pc_out), 64'(TRAP_VEC));
        check("trap_valid", 64'(pc_valid), 64'd1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("trap_nopend", 64'(pc_out), 64'(TRAP_VEC));

        // Trap with misaligned redirect: no error pulse
        cyc(1, 0, 1, 32'h203, 1, 0, 0);
        check("trap_misal", 64'(misalign_err), 64'd0);

        // Address wrap at top of the space
        cyc(1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("pc_wrap", 64'(pc_out), 64'h0);

        // Counter wrap
        while (fetch_cnt != '1) cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("cnt_wrap", 64'(fetch_cnt), 64'd0);

        // Reset while a redirect is parked
        cyc(1, 1, 1, 32'h700, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 0);
        check("rst_pend_pc", 64'(pc_out), 64'(RESET_VEC));
        cyc(1, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0);
        check("rst_pend_gone", 64'(pc_out), 64'(RESET_VEC + 32'd4));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            if ($urandom_range(0, 4) != 0) rpc[1:0] = 2'b00;
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0,
                rpc,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
